ammrv_ram_responder: RTL and testbench
======================================

Name: ammrv_ram_responder

Overview:
- Single-clock Avalon-MM pipelined responder (slave) with readdatavalid, backed by internal word RAM.
- Terminates the m_ side of the clock-domain bridges in the clk_2x domain. Replaces behavioural responder models in benches and serves as scratch RAM in designs.
- Reads have fixed pipelined latency. The number of outstanding reads is throttled with waitrequest. Writes honour byteenable.

Parameters:
- P_AW, 8, word address bits; RAM depth 2**P_AW words of 32 bits.
- P_READ_LATENCY, 2, cycles from read acceptance to readdatavalid; legal 1..8.
- P_MAX_PENDING, 2, max reads accepted but not yet returned; legal 1..P_READ_LATENCY.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_address  in  32  byte address; word index = s_address[P_AW+1:2]; other bits ignored (aliasing).
- s_byteenable  in  4  write byte lanes.
- s_writedata  in  32  write data.
- s_read  in  1  read request.
- s_write  in  1  write request.
- s_waitrequest  out  1  stall; a request is accepted in a cycle where it is asserted and s_waitrequest=0.
- s_readdata  out  32  read data; 0 when s_readdatavalid=0.
- s_readdatavalid  out  1  one-cycle read-data strobe.

Behaviour:
- Reset, while asserted:
  - s_waitrequest=1, s_readdatavalid=0, s_readdata=0.
  - Pending counter = 0 and latency pipeline valid bits cleared.
  - RAM contents are not reset.
- Reset asserted mid-operation: all in-flight reads are discarded with no readdatavalid. The first request after reset deasserts is handled normally.
- Write acceptance:
  - s_write=1 and s_waitrequest=0 at edge E: bytes with s_byteenable[i]=1 are written at E; other bytes are unchanged.
  - byteenable=0 is a legal no-op.
  - Writes are never stalled except by reset.
- Read acceptance (s_read=1, s_waitrequest=0 at edge E):
  - The RAM word is sampled at E.
  - s_readdatavalid=1 with that data in the cycle P_READ_LATENCY-1 cycles after the first cycle following E. For P_READ_LATENCY=1 this is the cycle immediately after E.
- Ordering:
  - Responses are returned strictly in acceptance order, one per accepted read.
  - Back-to-back reads give back-to-back valids when P_MAX_PENDING=P_READ_LATENCY.
- Read-after-write: a write accepted at edge E is visible to any read accepted at edge E+1 or later. No stale data.
- s_read and s_write both asserted (protocol violation): treated as a write only. No read response and no pending increment.
- Pending counter:
  - Increments on read acceptance and decrements in the cycle s_readdatavalid=1. Both in the same cycle leaves it unchanged.
  - Width is clog2(P_MAX_PENDING+1). It never exceeds P_MAX_PENDING and never underflows.
- s_waitrequest (combinational from counter and pipeline state): s_waitrequest = reset | (s_read & ~s_write & (pending - s_readdatavalid) >= P_MAX_PENDING).
  - The slot freed by a response in this cycle is reusable in the same cycle.
  - s_waitrequest is 0 while idle (no read/write asserted, not in reset).
- Latency pipeline: a shift register of P_READ_LATENCY valid bits plus a data path. Data for invalid slots is forced to 0 at the output.
- No internal state machine beyond the pipeline and counter. Throughput is 1 request/cycle when not throttled.

Test Plan:
- Reset for 4 cycles with s_read=1 held -> s_waitrequest=1 throughout, s_readdatavalid=0, no response after reset for reads asserted during reset.
- Write 0xDEADBEEF to 0x10 with be=0xF, then write 0x00000055 to 0x10 with be=0x1, then read 0x10 -> readdata=0xDEADBE55. With P_READ_LATENCY=2, valid appears exactly 2 cycles after the accept edge.
- P_READ_LATENCY=3, P_MAX_PENDING=3: 8 consecutive reads of addresses 0x0..0x1C preloaded with index values -> zero waitrequest cycles, 8 consecutive valids returning 0..7 in order.
- P_READ_LATENCY=4, P_MAX_PENDING=1: 4 reads held asserted -> each read stalled until the previous valid cycle, accepts spaced 4 cycles apart, pending never >1.
- Write 0x12345678 to 0x40 at edge E, read 0x40 at E+1 -> returns 0x12345678. Read to 0x40+(4<<P_AW) -> same data (aliasing).
- Assert reset for 1 cycle while 2 reads are in flight -> no readdatavalid for them, pending=0 after reset, next read returns correctly with nominal latency.

Source files
------------

// File: rtl/ammrv_ram_responder.sv
// Avalon-MM pipelined responder backed by an internal 32-bit word RAM.
// Fixed read latency, byte-enabled writes, outstanding reads throttled with waitrequest.
module ammrv_ram_responder #(
    parameter int P_AW           = 8,
    parameter int P_READ_LATENCY = 2,
    parameter int P_MAX_PENDING  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_address,
    input  logic [3:0]  s_byteenable,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    input  logic        s_write,
    output logic        s_waitrequest,
    output logic [31:0] s_readdata,
    output logic        s_readdatavalid
);

    localparam int CW = $clog2(P_MAX_PENDING + 1);
    localparam int DEPTH = 2 ** P_AW;
    localparam logic [CW:0] MAX_PEND = (CW + 1)'(P_MAX_PENDING);

    logic [31:0]               mem_q [DEPTH];
    logic [P_READ_LATENCY-1:0] vld_q;
    logic [31:0]               dat_q [P_READ_LATENCY];
    logic [CW-1:0]             pending_q;
    logic [CW-1:0]             pending_d;

    logic [P_AW-1:0] word_idx;
    logic            wr_acc;
    logic            rd_acc;
    logic            out_vld;
    logic [CW:0]     busy_slots;
    logic            unused_addr_bits;

    assign word_idx         = s_address[P_AW+1:2];
    assign unused_addr_bits = ^{s_address[31:P_AW+2], s_address[1:0]};

    // Read and write together is a write only: no read response, no pending slot.
    assign wr_acc = s_write & ~s_waitrequest;
    assign rd_acc = s_read & ~s_write & ~s_waitrequest;

    // Output gated by reset so nothing escapes from the pipeline while reset is held.
    assign out_vld = vld_q[P_READ_LATENCY-1] & ~reset;

    // A slot whose response leaves this cycle is already free for a new read.
    assign busy_slots    = {1'b0, pending_q} - (CW + 1)'(out_vld);
    assign s_waitrequest = reset | (s_read & ~s_write & (busy_slots >= MAX_PEND));

    assign s_readdatavalid = out_vld;
    assign s_readdata      = out_vld ? dat_q[P_READ_LATENCY-1] : 32'h0;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (s_byteenable[b]) begin
                    mem_q[word_idx][8*b +: 8] <= s_writedata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        dat_q[0] <= rd_acc ? mem_q[word_idx] : 32'h0;
        for (int i = P_READ_LATENCY - 1; i > 0; i--) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    always_comb begin
        pending_d = pending_q;
        case ({rd_acc, out_vld})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q     <= '0;
            pending_q <= '0;
        end else begin
            vld_q[0] <= rd_acc;
            for (int i = P_READ_LATENCY - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
            end
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_ammrv_ram_responder.sv
// Randomized scoreboard bench for ammrv_ram_responder: a word-array memory model
// plus a queue of expected responses, each tagged with the cycle it must appear in.
module tb_ammrv_ram_responder;

    localparam int AW    = 8;
    localparam int LAT   = 3;
    localparam int MAXP  = 2;
    localparam int DEPTH = 2 ** AW;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] s_address;
    logic [3:0]  s_byteenable;
    logic [31:0] s_writedata;
    logic        s_read;
    logic        s_write;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] m_idx;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    ammrv_ram_responder #(
        .P_AW(AW),
        .P_READ_LATENCY(LAT),
        .P_MAX_PENDING(MAXP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_address(s_address),
        .s_byteenable(s_byteenable),
        .s_writedata(s_writedata),
        .s_read(s_read),
        .s_write(s_write),
        .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign m_idx = (s_address >> 2) % 32'(DEPTH);

    // reference model: acceptance observed at the edge, memory updated, reads queued
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            exp_q.delete();
        end else if (!s_waitrequest && s_write) begin
            for (int b = 0; b < 4; b++) begin
                if (s_byteenable[b]) model_mem[m_idx][8*b +: 8] <= s_writedata[8*b +: 8];
            end
        end else if (!s_waitrequest && s_read) begin
            exp_q.push_back('{model_mem[m_idx], cyc + LAT});
        end
    end

    // monitor: compares outputs on the falling edge
    initial begin
        forever begin
            bit   due_now;
            int   live;
            logic exp_wait;
            @(negedge clk);
            due_now  = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            live     = exp_q.size() - (due_now ? 1 : 0);
            exp_wait = reset || (s_read && !s_write && live >= MAXP);
            tests++;
            if (s_waitrequest !== exp_wait) begin
                fails++;
                $display("FAIL waitrequest cyc=%0d got=%b exp=%b", cyc, s_waitrequest, exp_wait);
            end
            tests++;
            if (due_now && !reset) begin
                if (s_readdatavalid !== 1'b1 || s_readdata !== exp_q[0].data) begin
                    fails++;
                    $display("FAIL read_response cyc=%0d got valid=%b data=%h exp valid=1 data=%h",
                             cyc, s_readdatavalid, s_readdata, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end else begin
                if (due_now) void'(exp_q.pop_front());
                if (s_readdatavalid !== 1'b0 || s_readdata !== 32'h0) begin
                    fails++;
                    $display("FAIL idle_output cyc=%0d got valid=%b data=%h exp valid=0 data=0",
                             cyc, s_readdatavalid, s_readdata);
                end
            end
        end
    end

    // driver tasks
    task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] d);
        int n;
        bit ok;
        n = 0;
        s_read       = rd;
        s_write      = wr;
        s_address    = a;
        s_byteenable = be;
        s_writedata  = d;
        forever begin
            @(negedge clk);
            ok = !s_waitrequest;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout addr=%h got=stalled exp=accepted", a);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        s_read  = 1'b0;
        s_write = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int kind;
        reset        = 1'b1;
        s_read       = 1'b1;
        s_write      = 1'b0;
        s_address    = 32'h0;
        s_byteenable = 4'h0;
        s_writedata  = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        reset  = 1'b0;
        s_read = 1'b0;
        idle(2);

        for (int i = 0; i < DEPTH; i++) req(1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom());

        req(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        req(1'b0, 1'b1, 32'h10, 4'h1, 32'h00000055);
        req(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        idle(LAT + 1);

        for (int i = 0; i < 8; i++) req(1'b0, 1'b1, 32'(i * 4), 4'hF, 32'(i));
        for (int i = 0; i < 8; i++) req(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0);
        idle(LAT + 1);

        req(1'b0, 1'b1, 32'h40, 4'hF, 32'h12345678);
        req(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        req(1'b1, 1'b0, 32'h40 + (32'd4 << AW), 4'h0, 32'h0);
        req(1'b0, 1'b1, 32'h44, 4'h0, 32'hFFFFFFFF);
        req(1'b1, 1'b1, 32'h48, 4'hC, 32'hA5A5A5A5);
        req(1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
        req(1'b1, 1'b0, 32'h48, 4'h0, 32'h0);
        idle(LAT + 1);

        req(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        req(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
        s_read = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
        idle(LAT + 2);

        for (int i = 0; i < 1500; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3)      req(1'b1, 1'b0, $urandom(), 4'h0, 32'h0);
            else if (kind <= 6) req(1'b0, 1'b1, $urandom(), 4'($urandom_range(0, 15)), $urandom());
            else if (kind == 7) req(1'b1, 1'b1, $urandom(), 4'($urandom_range(0, 15)), $urandom());
            else                idle($urandom_range(1, 3));
        end
        idle(LAT + 3);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d outstanding exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
